// File: rtl/tdm_demux8_pkg.sv
// Shared types for the 8-channel TDM receive path.
// Channel count, select width and the frame-alignment FSM states.
package tdm_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] ch_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/tdm_demux8_if.sv
// Line-side and channel-side bundle of the TDM demux.
// master drives the serial line and selects; slave returns rebuilt channels.
interface tdm_demux8_if
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1
);

  logic [DATA_W-1:0]      din;
  logic                   din_valid;
  logic                   sync;
  logic                   mode;
  logic                   s1;
  logic                   s2;
  logic                   s3;
  logic [N_CH*DATA_W-1:0] y;
  logic                   frame_valid;
  ch_t                    ch_cnt;
  logic                   err;

  modport master (
    output din, din_valid, sync, mode,
    output s1, s2, s3,
    input  y, frame_valid, ch_cnt, err
  );

  modport slave (
    input  din, din_valid, sync, mode,
    input  s1, s2, s3,
    output y, frame_valid, ch_cnt, err
  );

endinterface

// File: rtl/tdm_demux8_dec3to8.sv
// Channel index to one-hot write enable.
// Shared by shadow writes (auto) and direct y writes (manual).
module dec3to8
  import tdm_pkg::*;
(
  input  ch_t             idx_i,
  input  logic            en_i,
  output logic [N_CH-1:0] oh_o
);

  always_comb begin
    oh_o = '0;
    if (en_i) oh_o = N_CH'(1) << idx_i;
  end

endmodule

// File: rtl/tdm_demux8.sv
// 8-channel TDM receiver: serial samples to parallel channels.
// Auto mode aligns frames on sync; manual mode writes by external select.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input logic          clk,
  input logic          rst_n,
  tdm_demux8_if.slave  bus
);

  localparam int YW = N_CH * DATA_W;

  state_e                        st_q, st_d;
  ch_t                           cnt_q, cnt_d;
  logic [N_CH-1:0][DATA_W-1:0]   sh_q, sh_d;
  logic [YW-1:0]                 y_q, y_d;
  logic                          fv_q, fv_d;
  logic                          err_q, err_d;

  ch_t             idx;
  logic [N_CH-1:0] we;

  // A sync sample is always channel 0, even mid-frame.
  assign idx = bus.mode ? {bus.s3, bus.s2, bus.s1}
             : (bus.sync ? '0 : cnt_q);

  dec3to8 u_dec (
    .idx_i (idx),
    .en_i  (bus.din_valid),
    .oh_o  (we)
  );

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    sh_d  = sh_q;
    y_d   = y_q;
    fv_d  = 1'b0;
    err_d = 1'b0;
    if (bus.mode) begin
      st_d  = IDLE;
      cnt_d = '0;
      for (int k = 0; k < N_CH; k++)
        if (we[k]) y_d[k*DATA_W +: DATA_W] = bus.din;
    end else if (bus.din_valid) begin
      unique case (st_q)
        IDLE: begin
          if (bus.sync) begin
            sh_d[0] = bus.din;
            cnt_d   = SEL_W'(1);
            st_d    = RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < N_CH; k++)
            if (we[k]) sh_d[k] = bus.din;
          if (bus.sync && cnt_q != '0) begin
            err_d = 1'b1;
            cnt_d = SEL_W'(1);
          end else if (cnt_q == SEL_W'(N_CH-1)) begin
            for (int k = 0; k < N_CH-1; k++)
              y_d[k*DATA_W +: DATA_W] = sh_q[k];
            y_d[YW-1 -: DATA_W] = bus.din;
            fv_d  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + SEL_W'(1);
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      sh_q  <= '0;
      y_q   <= '0;
      fv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
      y_q   <= y_d;
      fv_q  <= fv_d;
      err_q <= err_d;
    end
  end

  assign bus.y           = y_q;
  assign bus.frame_valid = fv_q;
  assign bus.ch_cnt      = cnt_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed vector bench for tdm_demux8.
// Table of per-cycle vectors plus reset and loopback sequences.
module tb_tdm_demux8;

  typedef struct {
    logic       v;
    logic       s;
    logic       m;
    logic [2:0] sel;
    logic       d;
    logic [7:0] y;
    logic       fv;
    logic       er;
    logic [2:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  tdm_demux8_if #(.DATA_W(1)) bus ();

  tdm_demux8 #(.DATA_W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] y,
                         input logic fv, input logic er,
                         input logic [2:0] cnt);
    chk({tag, " y"}, int'(bus.y), int'(y));
    chk({tag, " fv"}, int'(bus.frame_valid), int'(fv));
    chk({tag, " err"}, int'(bus.err), int'(er));
    chk({tag, " cnt"}, int'(bus.ch_cnt), int'(cnt));
  endtask

  task automatic add(input logic v, input logic s, input logic m,
                     input logic [2:0] sel, input logic d,
                     input logic [7:0] y, input logic fv,
                     input logic er, input logic [2:0] cnt);
    vec_t t;
    t.v = v; t.s = s; t.m = m; t.sel = sel; t.d = d;
    t.y = y; t.fv = fv; t.er = er; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    bus.din_valid = t.v;
    bus.sync      = t.s;
    bus.mode      = t.m;
    {bus.s3, bus.s2, bus.s1} = t.sel;
    bus.din       = t.d;
    @(posedge clk);
    #1;
    chk_out(tag, t.y, t.fv, t.er, t.cnt);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] prev;
    vec_t       t;

    bus.din = 1'b0; bus.din_valid = 1'b0; bus.sync = 1'b0;
    bus.mode = 1'b0; bus.s1 = 1'b0; bus.s2 = 1'b0; bus.s3 = 1'b0;

    // auto frame 1,0,1,1,0,0,1,0 -> 4D
    add(1,1,0,0,1, 8'h00,0,0,1);
    add(1,0,0,0,0, 8'h00,0,0,2);
    add(1,0,0,0,1, 8'h00,0,0,3);
    add(1,0,0,0,1, 8'h00,0,0,4);
    add(1,0,0,0,0, 8'h00,0,0,5);
    add(1,0,0,0,0, 8'h00,0,0,6);
    add(1,0,0,0,1, 8'h00,0,0,7);
    add(1,0,0,0,0, 8'h4D,1,0,0);
    // free-running frame without sync -> B2
    add(1,0,0,0,0, 8'h4D,0,0,1);
    add(1,0,0,0,1, 8'h4D,0,0,2);
    add(1,0,0,0,0, 8'h4D,0,0,3);
    add(1,0,0,0,0, 8'h4D,0,0,4);
    add(1,0,0,0,1, 8'h4D,0,0,5);
    add(1,0,0,0,1, 8'h4D,0,0,6);
    add(1,0,0,0,0, 8'h4D,0,0,7);
    add(1,0,0,0,1, 8'hB2,1,0,0);
    // 4D again with gaps; sync during a gap is ignored
    add(1,1,0,0,1, 8'hB2,0,0,1);
    add(0,1,0,0,0, 8'hB2,0,0,1);
    add(1,0,0,0,0, 8'hB2,0,0,2);
    add(0,0,0,0,1, 8'hB2,0,0,2);
    add(1,0,0,0,1, 8'hB2,0,0,3);
    add(0,0,0,0,0, 8'hB2,0,0,3);
    add(1,0,0,0,1, 8'hB2,0,0,4);
    add(0,1,0,0,1, 8'hB2,0,0,4);
    add(1,0,0,0,0, 8'hB2,0,0,5);
    add(0,0,0,0,1, 8'hB2,0,0,5);
    add(1,0,0,0,0, 8'hB2,0,0,6);
    add(0,0,0,0,0, 8'hB2,0,0,6);
    add(1,0,0,0,1, 8'hB2,0,0,7);
    add(0,0,0,0,1, 8'hB2,0,0,7);
    add(1,0,0,0,0, 8'h4D,1,0,0);
    // sync at ch5 -> err, restart; new frame -> 0F
    add(1,1,0,0,0, 8'h4D,0,0,1);
    add(1,0,0,0,0, 8'h4D,0,0,2);
    add(1,0,0,0,0, 8'h4D,0,0,3);
    add(1,0,0,0,0, 8'h4D,0,0,4);
    add(1,0,0,0,0, 8'h4D,0,0,5);
    add(1,1,0,0,1, 8'h4D,0,1,1);
    add(1,0,0,0,1, 8'h4D,0,0,2);
    add(1,0,0,0,1, 8'h4D,0,0,3);
    add(1,0,0,0,1, 8'h4D,0,0,4);
    add(1,0,0,0,0, 8'h4D,0,0,5);
    add(1,0,0,0,0, 8'h4D,0,0,6);
    add(1,0,0,0,0, 8'h4D,0,0,7);
    add(1,0,0,0,0, 8'h0F,1,0,0);
    // partial auto frame, then manual mode drops it
    add(1,1,0,0,1, 8'h0F,0,0,1);
    add(1,0,0,0,1, 8'h0F,0,0,2);
    add(1,0,1,0,0, 8'h0E,0,0,0);
    add(1,0,1,1,0, 8'h0C,0,0,0);
    add(1,0,1,2,0, 8'h08,0,0,0);
    add(1,0,1,3,0, 8'h00,0,0,0);
    add(1,0,1,6,1, 8'h40,0,0,0);
    add(1,1,1,1,1, 8'h42,0,0,0);
    add(0,0,1,5,1, 8'h42,0,0,0);
    // back in auto: IDLE ignores unsynced samples
    add(1,0,0,0,1, 8'h42,0,0,0);
    add(1,1,0,0,0, 8'h42,0,0,1);
    add(1,0,0,0,1, 8'h42,0,0,2);
    add(1,0,0,0,1, 8'h42,0,0,3);
    add(1,0,0,0,0, 8'h42,0,0,4);
    add(1,0,0,0,0, 8'h42,0,0,5);
    add(1,0,0,0,1, 8'h42,0,0,6);
    add(1,0,0,0,1, 8'h42,0,0,7);
    add(1,0,0,0,0, 8'h66,1,0,0);

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // async reset in the middle of a frame
    t.v = 1; t.s = 1; t.m = 0; t.sel = 0; t.d = 1;
    t.y = 8'h66; t.fv = 0; t.er = 0; t.cnt = 1;
    apply(t, "pre-rst0");
    t.s = 0; t.d = 0; t.cnt = 2;
    apply(t, "pre-rst1");
    #2;
    bus.din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_out("async-rst", 8'h00, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_out("rst-held", 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    t.v = 1; t.s = 0; t.d = 1; t.y = 8'h00; t.cnt = 0;
    apply(t, "post-rst-idle");

    // loopback from a mux8 model, select counted 0..7
    prev = 8'h00;
    for (int f = 0; f < 5; f++) begin
      case (f)
        0: pat = 8'hA5;
        1: pat = 8'h3C;
        2: pat = 8'h81;
        default: pat = 8'($urandom);
      endcase
      for (int c = 0; c < 8; c++) begin
        t.v = 1; t.m = 0; t.sel = 0;
        t.s = (c == 0);
        t.d = pat[c];
        t.y = (c == 7) ? pat : prev;
        t.fv = (c == 7);
        t.er = 0;
        t.cnt = 3'(c + 1);
        apply(t, $sformatf("loop%0d.%0d", f, c));
      end
      prev = pat;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
